// File: rtl/trace_filter_config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : trace_filter_cfg_pkg
// Description : Opcodes, header field positions and FSM states for the trace
//               filter configuration loader.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_filter_cfg_pkg;

    typedef enum logic [3:0] {
        OP_WRITE_SEED  = 4'd1,
        OP_WRITE_RANGE = 4'd2,
        OP_CLEAR_ALL   = 4'd3
    } opcode_e;

    localparam int c_OPC_LSB       = 28;
    localparam int c_OPC_W         = 4;
    localparam int c_SEED_IDX_LSB  = 8;
    localparam int c_RANGE_IDX_LSB = 0;
    localparam int c_IDX_W         = 8;
    localparam int c_UB_LSB        = 16;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SEED_DATA  = 3'd1,
        S_RANGE_DATA = 3'd2,
        S_COMMIT     = 3'd3,
        S_CLEAR      = 3'd4,
        S_SETTLE     = 3'd5,
        S_DRAIN      = 3'd6
    } state_e;

    function automatic logic idx_in_range(input logic [c_IDX_W-1:0] idx, input int limit);
        return int'({{(32-c_IDX_W){1'b0}}, idx}) < limit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_filter_config_loader_cfg_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : cfg_word_assembler
// Description : Shifts WORD_WIDTH words LS-word first into a DATA_WIDTH
//               register; o_done flags the shift that completes the value.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_word_assembler #(
    parameter int DATA_WIDTH = 512,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_shift,
    input  logic [WORD_WIDTH-1:0] i_word,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_done
);

    localparam int c_WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int c_CNT_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;

    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_last;

    assign w_last = (r_count == c_CNT_W'(c_WORDS - 1));
    assign o_done = i_shift & w_last;
    assign o_data = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_shift) begin
            r_count <= w_last ? '0 : r_count + c_CNT_W'(1);
        end
    end

    generate
        if (c_WORDS > 1) begin : g_multi
            // New words enter at the top so the first word ends up at bit 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (i_clear) begin
                    r_data <= '0;
                end else if (i_shift) begin
                    r_data <= {i_word, r_data[DATA_WIDTH-1:WORD_WIDTH]};
                end
            end
        end else begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (i_clear) begin
                    r_data <= '0;
                end else if (i_shift) begin
                    r_data <= i_word;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/trace_filter_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : trace_filter_config_loader
// Description : Decodes the config stream into seed/range writes and bulk
//               clears, gating the filter enable while updates are in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_filter_config_loader
    import trace_filter_cfg_pkg::*;
#(
    parameter int DETERMINISTIC_DATA_WIDTH = 512,
    parameter int CFG_WIDTH                = 32,
    parameter int NUM_OF_SEEDS             = 1,
    parameter int RANGES_PER_SEED          = 1,
    parameter int SEEDS_ADDR_WIDTH         = 1,
    parameter int RANGES_ADDR_WIDTH        = 1,
    parameter int BIT_COUNTS_WIDTH         = 10,
    parameter int SETTLE_CYCLES            = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [CFG_WIDTH-1:0]                cfg_data,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic                                trace_en_in,
    input  logic                                err_clear,
    output logic                                filter_en,
    output logic [DETERMINISTIC_DATA_WIDTH-1:0] seed_input,
    output logic [SEEDS_ADDR_WIDTH-1:0]         seed_address,
    output logic                                seed_write_enable,
    output logic [BIT_COUNTS_WIDTH-1:0]         lower_bound_input,
    output logic [BIT_COUNTS_WIDTH-1:0]         upper_bound_input,
    output logic [RANGES_ADDR_WIDTH-1:0]        range_address,
    output logic                                range_write_enable,
    output logic                                busy,
    output logic                                cmd_done,
    output logic                                err_opcode,
    output logic                                err_index
);

    localparam int c_WORDS   = DETERMINISTIC_DATA_WIDTH / CFG_WIDTH;
    localparam int c_CNT_MAX = (c_WORDS > SETTLE_CYCLES) ? c_WORDS : SETTLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    state_e                        r_state;
    logic [c_CNT_W-1:0]            r_cnt;
    logic [SEEDS_ADDR_WIDTH-1:0]   r_seed_addr;
    logic [RANGES_ADDR_WIDTH-1:0]  r_range_addr;
    logic [BIT_COUNTS_WIDTH-1:0]   r_lower;
    logic [BIT_COUNTS_WIDTH-1:0]   r_upper;
    logic                          r_seed_we;
    logic                          r_range_we;
    logic                          r_cmd_done;
    logic                          r_err_op;
    logic                          r_err_idx;
    logic                          r_filter_en;

    logic                          w_accept;
    opcode_e                       w_opcode;
    logic [c_IDX_W-1:0]            w_seed_idx;
    logic [c_IDX_W-1:0]            w_range_idx;
    logic                          w_seed_ok;
    logic                          w_range_ok;
    logic                          w_asm_clear;
    logic                          w_asm_shift;
    logic                          w_asm_done;
    logic [DETERMINISTIC_DATA_WIDTH-1:0] w_asm_data;
    logic                          w_last_range;
    logic                          w_last_seed;

    assign cfg_ready = (r_state == S_IDLE) || (r_state == S_SEED_DATA) ||
                       (r_state == S_RANGE_DATA) || (r_state == S_DRAIN);
    assign w_accept  = cfg_valid & cfg_ready;

    assign w_opcode    = opcode_e'(cfg_data[c_OPC_LSB +: c_OPC_W]);
    assign w_seed_idx  = cfg_data[c_SEED_IDX_LSB +: c_IDX_W];
    assign w_range_idx = cfg_data[c_RANGE_IDX_LSB +: c_IDX_W];
    assign w_seed_ok   = idx_in_range(w_seed_idx, NUM_OF_SEEDS);
    assign w_range_ok  = idx_in_range(w_range_idx, RANGES_PER_SEED);

    // Every header wipes the assembler, so a CLEAR also drives seed_input to 0.
    assign w_asm_clear = w_accept && (r_state == S_IDLE);
    assign w_asm_shift = w_accept && (r_state == S_SEED_DATA);

    assign w_last_range = (r_range_addr == RANGES_ADDR_WIDTH'(RANGES_PER_SEED - 1));
    assign w_last_seed  = (r_seed_addr == SEEDS_ADDR_WIDTH'(NUM_OF_SEEDS - 1));

    cfg_word_assembler #(
        .DATA_WIDTH (DETERMINISTIC_DATA_WIDTH),
        .WORD_WIDTH (CFG_WIDTH)
    ) u_assembler (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_asm_clear),
        .i_shift (w_asm_shift),
        .i_word  (cfg_data),
        .o_data  (w_asm_data),
        .o_done  (w_asm_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_seed_addr  <= '0;
            r_range_addr <= '0;
            r_lower      <= '0;
            r_upper      <= '0;
            r_seed_we    <= 1'b0;
            r_range_we   <= 1'b0;
            r_cmd_done   <= 1'b0;
            r_err_op     <= 1'b0;
            r_err_idx    <= 1'b0;
            r_filter_en  <= 1'b0;
        end else begin
            r_cmd_done  <= 1'b0;
            r_filter_en <= trace_en_in & (r_state == S_IDLE);
            // Placed first so an error raised below in the same cycle wins.
            if (err_clear) begin
                r_err_op  <= 1'b0;
                r_err_idx <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (w_opcode)
                            OP_WRITE_SEED: begin
                                if (w_seed_ok) begin
                                    r_seed_addr <= w_seed_idx[SEEDS_ADDR_WIDTH-1:0];
                                    r_state     <= S_SEED_DATA;
                                end else begin
                                    r_err_idx <= 1'b1;
                                    r_cnt     <= c_CNT_W'(c_WORDS);
                                    r_state   <= S_DRAIN;
                                end
                            end
                            OP_WRITE_RANGE: begin
                                if (w_seed_ok && w_range_ok) begin
                                    r_seed_addr  <= w_seed_idx[SEEDS_ADDR_WIDTH-1:0];
                                    r_range_addr <= w_range_idx[RANGES_ADDR_WIDTH-1:0];
                                    r_state      <= S_RANGE_DATA;
                                end else begin
                                    r_err_idx <= 1'b1;
                                    r_cnt     <= c_CNT_W'(1);
                                    r_state   <= S_DRAIN;
                                end
                            end
                            OP_CLEAR_ALL: begin
                                r_seed_addr  <= '0;
                                r_range_addr <= '0;
                                r_lower      <= '0;
                                r_upper      <= '1;
                                r_seed_we    <= 1'b1;
                                r_range_we   <= 1'b1;
                                r_state      <= S_CLEAR;
                            end
                            default: begin
                                r_err_op   <= 1'b1;
                                r_cmd_done <= 1'b1;
                            end
                        endcase
                    end
                end
                S_SEED_DATA: begin
                    if (w_asm_done) begin
                        r_seed_we <= 1'b1;
                        r_state   <= S_COMMIT;
                    end
                end
                S_RANGE_DATA: begin
                    if (w_accept) begin
                        r_lower    <= cfg_data[BIT_COUNTS_WIDTH-1:0];
                        r_upper    <= cfg_data[c_UB_LSB +: BIT_COUNTS_WIDTH];
                        r_range_we <= 1'b1;
                        r_state    <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_seed_we  <= 1'b0;
                    r_range_we <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= S_SETTLE;
                end
                S_CLEAR: begin
                    if (w_last_range) begin
                        r_range_addr <= '0;
                        if (w_last_seed) begin
                            r_seed_we  <= 1'b0;
                            r_range_we <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= S_SETTLE;
                        end else begin
                            r_seed_addr <= r_seed_addr + SEEDS_ADDR_WIDTH'(1);
                        end
                    end else begin
                        r_range_addr <= r_range_addr + RANGES_ADDR_WIDTH'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == c_CNT_W'(SETTLE_CYCLES - 1)) begin
                        r_cmd_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_accept) begin
                        if (r_cnt == c_CNT_W'(1)) begin
                            r_cmd_done <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - c_CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy               = (r_state != S_IDLE);
    assign filter_en          = r_filter_en;
    assign seed_input         = w_asm_data;
    assign seed_address       = r_seed_addr;
    assign seed_write_enable  = r_seed_we;
    assign lower_bound_input  = r_lower;
    assign upper_bound_input  = r_upper;
    assign range_address      = r_range_addr;
    assign range_write_enable = r_range_we;
    assign cmd_done           = r_cmd_done;
    assign err_opcode         = r_err_op;
    assign err_index          = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_trace_filter_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_filter_config_loader
// Description : Scoreboard bench: directed commands queue expected writes and
//               completions; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_filter_config_loader;

    localparam int DW = 512;
    localparam int CW = 32;
    localparam int BW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          trace_en_in = 1'b1;
    logic          err_clear = 1'b0;
    logic          filter_en;
    logic [DW-1:0] seed_input;
    logic [0:0]    seed_address;
    logic          seed_write_enable;
    logic [BW-1:0] lower_bound_input;
    logic [BW-1:0] upper_bound_input;
    logic [0:0]    range_address;
    logic          range_write_enable;
    logic          busy;
    logic          cmd_done;
    logic          err_opcode;
    logic          err_index;

    always #5 clk = ~clk;

    trace_filter_config_loader #(
        .DETERMINISTIC_DATA_WIDTH (DW),
        .CFG_WIDTH                (CW),
        .NUM_OF_SEEDS             (2),
        .RANGES_PER_SEED          (2),
        .SEEDS_ADDR_WIDTH         (1),
        .RANGES_ADDR_WIDTH        (1),
        .BIT_COUNTS_WIDTH         (BW),
        .SETTLE_CYCLES            (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_data           (cfg_data),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .trace_en_in        (trace_en_in),
        .err_clear          (err_clear),
        .filter_en          (filter_en),
        .seed_input         (seed_input),
        .seed_address       (seed_address),
        .seed_write_enable  (seed_write_enable),
        .lower_bound_input  (lower_bound_input),
        .upper_bound_input  (upper_bound_input),
        .range_address      (range_address),
        .range_write_enable (range_write_enable),
        .busy               (busy),
        .cmd_done           (cmd_done),
        .err_opcode         (err_opcode),
        .err_index          (err_index)
    );

    typedef struct {
        bit            is_done;
        bit            swe;
        bit            rwe;
        bit            saddr;
        bit            raddr;
        logic [DW-1:0] sdata;
        logic [BW-1:0] lo;
        logic [BW-1:0] up;
        bit            eop;
        bit            eidx;
    } ev_t;

    ev_t exp_q[$];
    ev_t m_e;
    bit  m_ok;
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  low_run = 0;
    int  last_low_run = 0;

    function automatic void push_wr(bit swe, bit rwe, bit sa, bit ra,
                                    logic [DW-1:0] sd, logic [BW-1:0] lo, logic [BW-1:0] up);
        ev_t e;
        e.is_done = 1'b0; e.swe = swe; e.rwe = rwe; e.saddr = sa; e.raddr = ra;
        e.sdata = sd; e.lo = lo; e.up = up; e.eop = 1'b0; e.eidx = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_done(bit eop, bit eidx);
        ev_t e;
        e.is_done = 1'b1; e.swe = 1'b0; e.rwe = 1'b0; e.saddr = 1'b0; e.raddr = 1'b0;
        e.sdata = '0; e.lo = '0; e.up = '0; e.eop = eop; e.eidx = eidx;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every write pulse or cmd_done must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (seed_write_enable || range_write_enable || cmd_done)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: actual swe=%0b rwe=%0b done=%0b required none",
                         seed_write_enable, range_write_enable, cmd_done);
            end else begin
                m_e = exp_q.pop_front();
                if (m_e.is_done)
                    m_ok = cmd_done && !seed_write_enable && !range_write_enable &&
                           (err_opcode == m_e.eop) && (err_index == m_e.eidx);
                else
                    m_ok = !cmd_done && (seed_write_enable == m_e.swe) &&
                           (range_write_enable == m_e.rwe) && (seed_address == m_e.saddr) &&
                           (!m_e.rwe || (range_address == m_e.raddr &&
                                         lower_bound_input == m_e.lo &&
                                         upper_bound_input == m_e.up)) &&
                           (!m_e.swe || seed_input == m_e.sdata);
                if (!m_ok)
                    $display("FAIL %s: actual swe=%0b rwe=%0b done=%0b sa=%0d ra=%0d lo=%0h up=%0h eop=%0b eidx=%0b sd=%0h required swe=%0b rwe=%0b sa=%0d ra=%0d lo=%0h up=%0h eop=%0b eidx=%0b sd=%0h",
                             m_e.is_done ? "cmd_done" : "write",
                             seed_write_enable, range_write_enable, cmd_done, seed_address,
                             range_address, lower_bound_input, upper_bound_input, err_opcode,
                             err_index, seed_input, m_e.swe, m_e.rwe, m_e.saddr, m_e.raddr,
                             m_e.lo, m_e.up, m_e.eop, m_e.eidx, m_e.sdata);
                if (!m_ok) n_fail++;
            end
        end
    end

    always @(negedge clk) begin
        if (!filter_en) begin
            low_run <= low_run + 1;
        end else begin
            if (low_run > 0) last_low_run <= low_run;
            low_run <= 0;
        end
    end

    task automatic send(input logic [31:0] d);
        int n;
        @(negedge clk);
        cfg_data  = d;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: actual cfg_ready=0 required 1 for word %h", d);
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, {62'd0, busy, exp_q.size() == 0}, 64'h1);
        repeat (3) @(negedge clk);
    endtask

    logic [DW-1:0] sd;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {57'd0, filter_en, seed_write_enable, range_write_enable, busy,
                                cmd_done, err_opcode, err_index}, 64'h0);
        check("reset_seed_input", {63'd0, seed_input == '0}, 64'h1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_filter_en", {62'd0, cfg_ready, filter_en}, 64'h3);

        // 1: seed write, words 0..15 into seed 0
        for (int k = 0; k < 16; k++) sd[k*32 +: 32] = k;
        push_wr(1'b1, 1'b0, 1'b0, 1'b0, sd, '0, '0);
        push_done(1'b0, 1'b0);
        send(32'h1000_0000);
        for (int k = 0; k < 16; k++) send(k);
        wait_quiet("seed_cmd_complete");
        check("seed_filter_en_low_ge3", {63'd0, last_low_run >= 3}, 64'h1);
        check("seed_filter_en_restored", {63'd0, filter_en}, 64'h1);

        // 2: range write seed 0 range 0
        push_wr(1'b0, 1'b1, 1'b0, 1'b0, '0, 10'h005, 10'h120);
        push_done(1'b0, 1'b0);
        send(32'h2000_0000);
        send(32'h0120_0005);
        wait_quiet("range_cmd_complete");
        check("range_filter_en_low_ge3", {63'd0, last_low_run >= 3}, 64'h1);

        // 3: clear all over 2x2 pairs
        push_wr(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 10'h3FF);
        push_wr(1'b1, 1'b1, 1'b0, 1'b1, '0, '0, 10'h3FF);
        push_wr(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 10'h3FF);
        push_wr(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, 10'h3FF);
        push_done(1'b0, 1'b0);
        send(32'h3000_0000);
        wait_quiet("clear_cmd_complete");

        // 4: seed index 5 out of range, all 16 words drained
        push_done(1'b0, 1'b1);
        send(32'h1000_0500);
        check("err_index_set_on_header", {62'd0, err_index, busy}, 64'h3);
        for (int k = 0; k < 16; k++) send(32'hDEAD_0000 + k);
        wait_quiet("drain_cmd_complete");
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        check("err_index_cleared", {63'd0, err_index}, 64'h0);

        // 5: illegal opcode with err_clear in the same cycle; next word is a header
        push_done(1'b1, 1'b0);
        @(negedge clk); err_clear = 1'b1;
        send(32'h7000_0000);
        err_clear = 1'b0;
        push_wr(1'b0, 1'b1, 1'b1, 1'b1, '0, 10'h000, 10'h3FF);
        push_done(1'b1, 1'b0);
        send(32'h2000_0101);
        send(32'h03FF_0000);
        wait_quiet("header_after_bad_opcode");
        check("err_opcode_sticky", {62'd0, err_opcode, err_index}, 64'h2);

        // Range index 2 out of range: one payload word drained
        push_done(1'b1, 1'b1);
        send(32'h2000_0002);
        send(32'hFFFF_FFFF);
        wait_quiet("range_drain_complete");
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        check("both_errors_cleared", {62'd0, err_opcode, err_index}, 64'h0);

        // 6: reset in the middle of a seed payload
        send(32'h1000_0100);
        for (int k = 0; k < 7; k++) send(32'h5555_0000 + k);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_cmd", {59'd0, seed_write_enable, range_write_enable, busy, cmd_done,
                                seed_input == '0}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {62'd0, busy, cfg_ready}, 64'h1);

        for (int k = 0; k < 16; k++) sd[k*32 +: 32] = 32'hA500_0000 + k;
        push_wr(1'b1, 1'b0, 1'b1, 1'b0, sd, '0, '0);
        push_done(1'b0, 1'b0);
        send(32'h1000_0100);
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(32'hA500_0000 + k);
        end
        wait_quiet("seed_after_reset_complete");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
